lcd_nibble_driver: RTL

- Character-LCD physical driver for the Spartan-3E starter board's HD44780-compatible display in 4-bit mode.
- Consumes level requests plus an 8-bit operand from the upstream LCD sequencer and returns sticky done flags.
- Generates RS/RW/E/DB[7:4] with HD44780 timing, including the power-on init sequence.
- Sits between the sequencer and the LCD pins.

---
 rtl/lcd_pkg.sv | 48 ++++
 rtl/lcd_nibble_tx.sv | 102 ++++++++++
 rtl/lcd_nibble_driver.sv | 272 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/lcd_pkg.sv
// Shared definitions for the character-LCD driver:
//   - HD44780 command bytes used by the init sequence and the requests
//   - default timing constants (50 MHz CCLK)
//   - FSM state encodings for the top sequencer and the nibble transmitter
package lcd_pkg;

    localparam logic [7:0] CMD_FUNC    = 8'h28;  // 4-bit bus, 2 lines, 5x8 font
    localparam logic [7:0] CMD_ENTRY   = 8'h06;  // increment, no shift
    localparam logic [7:0] CMD_DISP    = 8'h0C;  // display on, cursor off
    localparam logic [7:0] CMD_CLEAR   = 8'h01;
    localparam logic [7:0] CMD_HOME    = 8'h02;
    localparam logic [7:0] CMD_SETADDR = 8'h80;

    localparam int unsigned DEF_T_PWRON = 750000;
    localparam int unsigned DEF_T_INIT1 = 205000;
    localparam int unsigned DEF_T_INIT2 = 5000;
    localparam int unsigned DEF_T_CMD   = 2000;
    localparam int unsigned DEF_T_CLEAR = 82000;
    localparam int unsigned DEF_T_SETUP = 2;
    localparam int unsigned DEF_T_E     = 12;
    localparam int unsigned DEF_T_NIB   = 50;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PWR,
        ST_INIT_NIB,
        ST_BYTE_HI,
        ST_BYTE_LO,
        ST_WAIT,
        ST_DONE
    } lcd_state_t;

    typedef enum logic [2:0] {
        REQ_RESET,
        REQ_CLEAR,
        REQ_HOME,
        REQ_ADDR,
        REQ_DATA
    } lcd_req_t;

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_SETUP,
        TX_EHIGH,
        TX_GAP
    } tx_phase_t;

endpackage

// File: rtl/lcd_nibble_tx.sv
// Single-nibble writer for the HD44780 4-bit bus.
//   CCLK, reset   : clock, async active-low reset
//   start         : begin a nibble (accepted when idle or in the last gap cycle)
//   rs, nibble    : RS level and DB[7:4] value for this nibble
//   clr           : return rslcd/lcdd to 0 while idle
//   elcd, lcdd,
//   rslcd         : LCD pins (registered)
//   busy          : a nibble is in progress
//   done          : one-cycle strobe, one cycle before the gap ends
//
// state    | meaning
// TX_IDLE  | no nibble in flight; pins held (or cleared by clr)
// TX_SETUP | RS/DB driven, E low, T_SETUP cycles
// TX_EHIGH | E high, T_E cycles
// TX_GAP   | E low, RS/DB held, T_NIB cycles (hold + inter-nibble gap)
module lcd_nibble_tx
    import lcd_pkg::*;
#(
    parameter int unsigned T_SETUP = DEF_T_SETUP,
    parameter int unsigned T_E     = DEF_T_E,
    parameter int unsigned T_NIB   = DEF_T_NIB
) (
    input  logic       CCLK,
    input  logic       reset,
    input  logic       start,
    input  logic       rs,
    input  logic [3:0] nibble,
    input  logic       clr,
    output logic       elcd,
    output logic [3:0] lcdd,
    output logic       rslcd,
    output logic       busy,
    output logic       done
);

    tx_phase_t   phase;
    logic [15:0] cnt;

    assign busy = (phase != TX_IDLE);
    // Raised one cycle early so a caller's registered start lands exactly in
    // the last gap cycle and the next setup follows with no extra idle cycle.
    // This needs T_NIB >= 2.
    assign done = (phase == TX_GAP) && (cnt == 16'd1);

    always_ff @(posedge CCLK or negedge reset) begin
        if (!reset) begin
            phase <= TX_IDLE;
            cnt   <= '0;
            elcd  <= 1'b0;
            lcdd  <= '0;
            rslcd <= 1'b0;
        end else begin
            unique case (phase)
                TX_IDLE: begin
                    if (start) begin
                        phase <= TX_SETUP;
                        cnt   <= 16'(T_SETUP - 1);
                        lcdd  <= nibble;
                        rslcd <= rs;
                    end else if (clr) begin
                        lcdd  <= '0;
                        rslcd <= 1'b0;
                    end
                end
                TX_SETUP: begin
                    if (cnt == '0) begin
                        phase <= TX_EHIGH;
                        cnt   <= 16'(T_E - 1);
                        elcd  <= 1'b1;
                    end else begin
                        cnt <= cnt - 16'd1;
                    end
                end
                TX_EHIGH: begin
                    if (cnt == '0) begin
                        phase <= TX_GAP;
                        cnt   <= 16'(T_NIB - 1);
                        elcd  <= 1'b0;
                    end else begin
                        cnt <= cnt - 16'd1;
                    end
                end
                TX_GAP: begin
                    if (cnt == '0) begin
                        if (start) begin
                            phase <= TX_SETUP;
                            cnt   <= 16'(T_SETUP - 1);
                            lcdd  <= nibble;
                            rslcd <= rs;
                        end else begin
                            phase <= TX_IDLE;
                        end
                    end else begin
                        cnt <= cnt - 16'd1;
                    end
                end
                default: phase <= TX_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/lcd_nibble_driver.sv
// HD44780 4-bit physical driver: power-on init, clear, home, set-address and
// character write, each reported through a sticky done flag.
//   CCLK, reset            : clock, async active-low reset
//   resetlcd .. datalcd    : level requests (priority reset>clear>home>addr>data)
//   lcddatin               : operand for addr/data, latched at acceptance
//   initlcd                : clears all done flags
//   lcdreset .. lcddata    : sticky done flags
//   rslcd, rwlcd, elcd,
//   lcdd                   : LCD pins (rwlcd tied low)
//
// state       | meaning
// ST_IDLE     | waiting for a request with all flags clear
// ST_PWR      | power-on wait before the first init nibble
// ST_INIT_NIB | init nibbles 0x3,0x3,0x3,0x2 and their waits (step 0-3)
// ST_BYTE_HI  | high nibble of a byte in flight
// ST_BYTE_LO  | low nibble of a byte in flight
// ST_WAIT     | post-byte execution wait
// ST_DONE     | flag set; pins returned to 0 on the way back to idle
module lcd_nibble_driver
    import lcd_pkg::*;
#(
    parameter int unsigned T_PWRON = DEF_T_PWRON,
    parameter int unsigned T_INIT1 = DEF_T_INIT1,
    parameter int unsigned T_INIT2 = DEF_T_INIT2,
    parameter int unsigned T_CMD   = DEF_T_CMD,
    parameter int unsigned T_CLEAR = DEF_T_CLEAR,
    parameter int unsigned T_SETUP = DEF_T_SETUP,
    parameter int unsigned T_E     = DEF_T_E,
    parameter int unsigned T_NIB   = DEF_T_NIB
) (
    input  logic       CCLK,
    input  logic       reset,
    input  logic       resetlcd,
    input  logic       clearlcd,
    input  logic       homelcd,
    input  logic       addrlcd,
    input  logic       datalcd,
    input  logic [7:0] lcddatin,
    input  logic       initlcd,
    output logic       lcdreset,
    output logic       lcdclear,
    output logic       lcdhome,
    output logic       lcdaddr,
    output logic       lcddata,
    output logic       rslcd,
    output logic       rwlcd,
    output logic       elcd,
    output logic [3:0] lcdd
);

    lcd_state_t  state;
    lcd_req_t    req;
    logic [2:0]  step;
    logic [19:0] cnt;
    logic        inited;
    logic        in_wait;
    logic        tx_start;
    logic        tx_rs;
    logic [3:0]  tx_nib;
    logic [3:0]  lo_nib;
    logic        tx_busy;
    logic        tx_done;
    logic        tx_clr;

    logic        any_flag;
    logic        any_req;
    lcd_req_t    sel_req;
    logic [7:0]  sel_byte;
    logic        sel_rs;
    logic [2:0]  nxt_step;
    logic [7:0]  nxt_byte;
    logic [19:0] post_wait;

    function automatic logic [3:0] init_nib(input logic [2:0] s);
        return (s == 3'd3) ? 4'h2 : 4'h3;
    endfunction

    function automatic logic [19:0] init_wait(input logic [2:0] s);
        case (s)
            3'd0:    return 20'(T_INIT1);
            3'd1:    return 20'(T_INIT2);
            default: return 20'(T_CMD);
        endcase
    endfunction

    function automatic logic [7:0] init_byte(input logic [2:0] s);
        case (s)
            3'd4:    return CMD_FUNC;
            3'd5:    return CMD_ENTRY;
            3'd6:    return CMD_DISP;
            default: return CMD_CLEAR;
        endcase
    endfunction

    assign rwlcd    = 1'b0;
    assign tx_clr   = (state == ST_DONE);
    assign any_flag = lcdreset | lcdclear | lcdhome | lcdaddr | lcddata;
    assign any_req  = clearlcd | homelcd | addrlcd | datalcd;
    assign nxt_step = step + 3'd1;
    assign nxt_byte = init_byte(nxt_step);

    always_comb begin
        sel_req  = REQ_DATA;
        sel_byte = lcddatin;
        sel_rs   = 1'b1;
        if (clearlcd) begin
            sel_req  = REQ_CLEAR;
            sel_byte = CMD_CLEAR;
            sel_rs   = 1'b0;
        end else if (homelcd) begin
            sel_req  = REQ_HOME;
            sel_byte = CMD_HOME;
            sel_rs   = 1'b0;
        end else if (addrlcd) begin
            sel_req  = REQ_ADDR;
            sel_byte = CMD_SETADDR | {1'b0, lcddatin[6:0]};
            sel_rs   = 1'b0;
        end
    end

    always_comb begin
        post_wait = 20'(T_CMD);
        case (req)
            REQ_RESET: if (step == 3'd7) post_wait = 20'(T_CLEAR);
            REQ_CLEAR,
            REQ_HOME:  post_wait = 20'(T_CLEAR);
            default:   ;
        endcase
    end

    // Waits are loaded on tx_done, one cycle before the nibble gap ends, so a
    // load of N gives exactly N cycles after the gap.
    always_ff @(posedge CCLK or negedge reset) begin
        if (!reset) begin
            state    <= ST_IDLE;
            req      <= REQ_RESET;
            step     <= '0;
            cnt      <= '0;
            inited   <= 1'b0;
            in_wait  <= 1'b0;
            tx_start <= 1'b0;
            tx_rs    <= 1'b0;
            tx_nib   <= '0;
            lo_nib   <= '0;
            lcdreset <= 1'b0;
            lcdclear <= 1'b0;
            lcdhome  <= 1'b0;
            lcdaddr  <= 1'b0;
            lcddata  <= 1'b0;
        end else begin
            tx_start <= 1'b0;
            if (initlcd) begin
                lcdreset <= 1'b0;
                lcdclear <= 1'b0;
                lcdhome  <= 1'b0;
                lcdaddr  <= 1'b0;
                lcddata  <= 1'b0;
            end
            unique case (state)
                ST_IDLE: begin
                    if (!any_flag && !tx_busy) begin
                        if (resetlcd) begin
                            req    <= REQ_RESET;
                            inited <= 1'b0;
                            step   <= '0;
                            cnt    <= 20'(T_PWRON - 1);
                            state  <= ST_PWR;
                        end else if (inited && any_req) begin
                            req      <= sel_req;
                            tx_rs    <= sel_rs;
                            tx_nib   <= sel_byte[7:4];
                            lo_nib   <= sel_byte[3:0];
                            tx_start <= 1'b1;
                            state    <= ST_BYTE_HI;
                        end
                    end
                end
                ST_PWR: begin
                    if (cnt == '0) begin
                        tx_rs    <= 1'b0;
                        tx_nib   <= init_nib(step);
                        tx_start <= 1'b1;
                        in_wait  <= 1'b0;
                        state    <= ST_INIT_NIB;
                    end else begin
                        cnt <= cnt - 20'd1;
                    end
                end
                ST_INIT_NIB: begin
                    if (!in_wait) begin
                        if (tx_done) begin
                            cnt     <= init_wait(step);
                            in_wait <= 1'b1;
                        end
                    end else if (cnt == '0) begin
                        step     <= nxt_step;
                        tx_start <= 1'b1;
                        in_wait  <= 1'b0;
                        if (step == 3'd3) begin
                            tx_nib <= nxt_byte[7:4];
                            lo_nib <= nxt_byte[3:0];
                            state  <= ST_BYTE_HI;
                        end else begin
                            tx_nib <= init_nib(nxt_step);
                        end
                    end else begin
                        cnt <= cnt - 20'd1;
                    end
                end
                ST_BYTE_HI: begin
                    if (tx_done) begin
                        tx_nib   <= lo_nib;
                        tx_start <= 1'b1;
                        state    <= ST_BYTE_LO;
                    end
                end
                ST_BYTE_LO: begin
                    if (tx_done) begin
                        cnt   <= post_wait;
                        state <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (cnt == '0) begin
                        if (req == REQ_RESET && step != 3'd7) begin
                            step     <= nxt_step;
                            tx_nib   <= nxt_byte[7:4];
                            lo_nib   <= nxt_byte[3:0];
                            tx_start <= 1'b1;
                            state    <= ST_BYTE_HI;
                        end else begin
                            case (req)
                                REQ_RESET: begin
                                    lcdreset <= 1'b1;
                                    inited   <= 1'b1;
                                end
                                REQ_CLEAR: lcdclear <= 1'b1;
                                REQ_HOME:  lcdhome  <= 1'b1;
                                REQ_ADDR:  lcdaddr  <= 1'b1;
                                default:   lcddata  <= 1'b1;
                            endcase
                            state <= ST_DONE;
                        end
                    end else begin
                        cnt <= cnt - 20'd1;
                    end
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    lcd_nibble_tx #(
        .T_SETUP (T_SETUP),
        .T_E     (T_E),
        .T_NIB   (T_NIB)
    ) u_tx (
        .CCLK   (CCLK),
        .reset  (reset),
        .start  (tx_start),
        .rs     (tx_rs),
        .nibble (tx_nib),
        .clr    (tx_clr),
        .elcd   (elcd),
        .lcdd   (lcdd),
        .rslcd  (rslcd),
        .busy   (tx_busy),
        .done   (tx_done)
    );

endmodule
